// File: rtl/slot_intrpt_capture.sv
// rtl/slot_intrpt_capture.sv - per-slot interrupt sync, debounce, sticky edge capture, aggregate irq and snapshot read
module slot_intrpt_capture #(
  parameter int NUM_SLOTS            = 7,
  parameter int NUM_INTRPTS_PER_SLOT = 3,
  parameter int DEBOUNCE_CYCLES      = 1000,
  parameter int CNT_WIDTH            = 10,
  localparam int N                   = NUM_SLOTS * NUM_INTRPTS_PER_SLOT
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [N-1:0]                    pin_intrpt,
  input  logic [N-1:0]                    rise_en,
  input  logic [N-1:0]                    fall_en,
  input  logic [N-1:0]                    irq_mask,
  input  logic                            clr_valid,
  input  logic [N-1:0]                    clr_mask,
  output logic                            clr_ack,
  input  logic                            rd_req,
  input  logic [2:0]                      rd_slot,
  output logic                            rd_ack,
  output logic [2*NUM_INTRPTS_PER_SLOT-1:0] rd_data,
  output logic [N-1:0]                    intrpt_level,
  output logic [N-1:0]                    intrpt_status,
  output logic                            irq_n
);

  localparam int K = NUM_INTRPTS_PER_SLOT;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_ACK  = 1'b1;

  logic [N-1:0]         s1;
  logic [N-1:0]         s2;
  logic [N-1:0]         level;
  logic [N-1:0]         status;
  logic [N-1:0]         accept;
  logic [N-1:0]         rise;
  logic [N-1:0]         fall;
  logic [N-1:0]         clr_vec;
  logic [CNT_WIDTH-1:0] cnt [N];
  logic [0:0]           rd_state;
  logic [2*K-1:0]       rd_sel;

  // A line is accepted on the edge where it has disagreed with level for DEBOUNCE_CYCLES cycles.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = (s2[i] != level[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise    = accept & s2 & rise_en;
  assign fall    = accept & ~s2 & fall_en;
  assign clr_vec = clr_valid ? clr_mask : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1      <= '1;
      s2      <= '1;
      level   <= '1;
      status  <= '0;
      irq_n   <= 1'b1;
      clr_ack <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= pin_intrpt;
      s2 <= s1;
      for (int i = 0; i < N; i++) begin
        if (s2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          level[i] <= s2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      // Set after clear so a same-edge event survives the clear.
      status  <= (status & ~clr_vec) | rise | fall;
      irq_n   <= ~|(status & irq_mask);
      clr_ack <= clr_valid;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (int'(rd_slot) == s) begin
        rd_sel = {status[s*K +: K], level[s*K +: K]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state <= RD_IDLE;
      rd_ack   <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (rd_req) begin
            rd_data  <= rd_sel;
            rd_ack   <= 1'b1;
            rd_state <= RD_ACK;
          end
        end
        default: begin
          rd_ack   <= 1'b0;
          rd_state <= RD_IDLE;
        end
      endcase
    end
  end

  assign intrpt_level  = level;
  assign intrpt_status = status;

endmodule
